// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction memory port, decode output port and branch redirect input
interface fetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        redirect;
  logic [15:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, ir_valid, ir_out, pc_out,
    input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_out, pc_out,
    output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner issuing imem requests and buffering instructions for decode
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd4
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.master f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [15:0]   pc_q, pc_d, addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [15:0]   ir_mem_q [DEPTH];
  logic [15:0]   ir_mem_d [DEPTH];
  logic [15:0]   pc_mem_q [DEPTH];
  logic [15:0]   pc_mem_d [DEPTH];
  logic          pop, push, issue;
  always_comb begin
    pop      = (count_q != '0) && f.ir_ready && !f.redirect;
    push     = (state_q == WAIT) && f.imem_ack && !f.redirect;
    issue    = (state_q == IDLE) && !f.redirect && ((count_q - CW'(pop)) < CW'(DEPTH));
    state_d  = f.redirect ? ((state_q != IDLE && !f.imem_ack) ? DROP : IDLE)
             : (state_q == IDLE) ? (issue ? WAIT : IDLE)
             : (f.imem_ack ? IDLE : state_q);
    pc_d     = f.redirect ? f.redirect_pc : push ? pc_q + PC_STEP : pc_q;
    addr_d   = issue ? pc_q : addr_q;
    count_d  = f.redirect ? '0 : count_q + CW'(push) - CW'(pop);
    head_d   = f.redirect ? '0 : head_q + AW'(pop);
    tail_d   = f.redirect ? '0 : tail_q + AW'(push);
    ir_mem_d = ir_mem_q;
    pc_mem_d = pc_mem_q;
    if (push) begin
      ir_mem_d[tail_q] = f.imem_rdata;
      pc_mem_d[tail_q] = addr_q;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      ir_mem_q <= ir_mem_d;
      pc_mem_q <= pc_mem_d;
    end
  end
  assign f.imem_req  = state_q != IDLE;
  assign f.imem_addr = addr_q;
  assign f.ir_valid  = count_q != '0;
  assign f.ir_out    = ir_mem_q[head_q];
  assign f.pc_out    = pc_mem_q[head_q];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed phases with a scoreboard of expected decode outputs and a memory model
module tb_fetch_queue;
  logic clock = 0;
  logic reset = 1;
  logic ready = 0;
  logic redirect = 0;
  logic [15:0] rpc = 16'h0000;
  logic mem_ack = 0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] delay_addr = 16'hFFFF;
  int tests = 0;
  int fails = 0;
  int pops = 0;
  int mem_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] req_log[$];
  logic [31:0] e;
  logic prev_req = 0;
  logic [15:0] prev_addr = 16'h0000;
  fetch_queue_if bus();
  assign bus.imem_ack    = mem_ack;
  assign bus.imem_rdata  = mem_rdata;
  assign bus.ir_ready    = ready;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = rpc;
  fetch_queue #(.DEPTH(2), .RESET_PC(16'h0000), .PC_STEP(16'd4)) dut (
    .clock(clock),
    .reset(reset),
    .f(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [15:0] log_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 16'hDEAD;
  endfunction
  always @(negedge clock) begin
    if (reset || !bus.imem_req) begin
      mem_ack = 0;
      mem_cnt = 0;
    end else if (mem_cnt >= ((bus.imem_addr == delay_addr) ? 3 : 0)) begin
      mem_ack = 1;
      mem_rdata = 16'h1000 + bus.imem_addr;
      mem_cnt = 0;
    end else begin
      mem_ack = 0;
      mem_cnt++;
    end
  end
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.imem_req && prev_req) check("addr_stable", bus.imem_addr, prev_addr);
      if (bus.imem_req && !prev_req) req_log.push_back(bus.imem_addr);
      if (bus.ir_valid && ready && !redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got ir %h pc %h expected none", bus.ir_out, bus.pc_out);
        end else begin
          e = exp_q.pop_front();
          check("ir_out", bus.ir_out, e[31:16]);
          check("pc_out", bus.pc_out, e[15:0]);
        end
      end
    end
    prev_req = reset ? 1'b0 : bus.imem_req;
    prev_addr = bus.imem_addr;
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic expect_ir(input logic [15:0] ir, input logic [15:0] pc);
    exp_q.push_back({ir, pc});
  endtask
  task automatic wait_pops(input int n);
    int b = 0;
    while (pops < n && b < 60) begin
      step();
      b++;
    end
    check("pop_count", 16'(pops), 16'(n));
  endtask
  task automatic wait_req(input logic [15:0] a);
    int b = 0;
    while (!(bus.imem_req && bus.imem_addr == a) && b < 60) begin
      step();
      b++;
    end
    check("req_seen", bus.imem_addr, a);
  endtask
  task automatic end_phase();
    check("sb_empty", 16'(exp_q.size()), 16'd0);
    reset = 1;
    ready = 0;
    redirect = 0;
    step(2);
    req_log.delete();
    reset = 0;
  endtask
  initial begin
    int base;
    step(2);
    check("rst_req", 16'(bus.imem_req), 16'd0);
    check("rst_valid", 16'(bus.ir_valid), 16'd0);
    check("rst_ir", bus.ir_out, 16'h0000);
    check("rst_pc", bus.pc_out, 16'h0000);
    check("rst_addr", bus.imem_addr, 16'h0000);
    req_log.delete();
    reset = 0;
    // phase 1: zero-wait stream
    base = pops;
    expect_ir(16'h1000, 16'h0000);
    expect_ir(16'h1004, 16'h0004);
    expect_ir(16'h1008, 16'h0008);
    ready = 1;
    wait_pops(base + 3);
    ready = 0;
    check("p1_log0", log_at(0), 16'h0000);
    check("p1_log1", log_at(1), 16'h0004);
    check("p1_log2", log_at(2), 16'h0008);
    end_phase();
    // phase 2: backpressure fills the queue
    base = pops;
    step(6);
    check("p2_nreq", 16'(req_log.size()), 16'd2);
    check("p2_log0", log_at(0), 16'h0000);
    check("p2_log1", log_at(1), 16'h0004);
    check("p2_req_idle", 16'(bus.imem_req), 16'd0);
    check("p2_head_pc", bus.pc_out, 16'h0000);
    expect_ir(16'h1000, 16'h0000);
    ready = 1;
    step();
    ready = 0;
    step(4);
    check("p2_nreq2", 16'(req_log.size()), 16'd3);
    check("p2_log2", log_at(2), 16'h0008);
    check("p2_req_idle2", 16'(bus.imem_req), 16'd0);
    check("p2_head_pc2", bus.pc_out, 16'h0004);
    check("p2_pops", 16'(pops - base), 16'd1);
    end_phase();
    // phase 3: redirect during a delayed fetch
    delay_addr = 16'h0004;
    ready = 1;
    expect_ir(16'h1000, 16'h0000);
    expect_ir(16'h1040, 16'h0040);
    wait_req(16'h0004);
    redirect = 1;
    rpc = 16'h0040;
    step();
    redirect = 0;
    check("p3_drop_req", 16'(bus.imem_req), 16'd1);
    check("p3_drop_addr", bus.imem_addr, 16'h0004);
    check("p3_valid_c2", 16'(bus.ir_valid), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("p3_valid_low", 16'(bus.ir_valid), 16'd0);
    end
    step();
    check("p3_valid_hi", 16'(bus.ir_valid), 16'd1);
    check("p3_head_pc", bus.pc_out, 16'h0040);
    step();
    ready = 0;
    check("p3_log2", log_at(2), 16'h0040);
    delay_addr = 16'hFFFF;
    end_phase();
    // phase 4: redirect with simultaneous ack and pop
    base = pops;
    expect_ir(16'h1080, 16'h0080);
    wait_req(16'h0004);
    check("p4_one_entry", 16'(bus.ir_valid), 16'd1);
    ready = 1;
    redirect = 1;
    rpc = 16'h0080;
    step();
    redirect = 0;
    check("p4_flushed", 16'(bus.ir_valid), 16'd0);
    step();
    check("p4_no_push", 16'(bus.ir_valid), 16'd0);
    check("p4_req", 16'(bus.imem_req), 16'd1);
    check("p4_addr", bus.imem_addr, 16'h0080);
    wait_pops(base + 1);
    ready = 0;
    end_phase();
    // phase 5: fetch PC wrap
    base = pops;
    ready = 1;
    redirect = 1;
    rpc = 16'hFFFC;
    expect_ir(16'h0FFC, 16'hFFFC);
    expect_ir(16'h1000, 16'h0000);
    step();
    redirect = 0;
    wait_pops(base + 2);
    ready = 0;
    check("p5_log0", log_at(0), 16'hFFFC);
    check("p5_log1", log_at(1), 16'h0000);
    end_phase();
    // phase 6: reset while a request is outstanding
    base = pops;
    delay_addr = 16'h0004;
    wait_req(16'h0004);
    check("p6_valid", 16'(bus.ir_valid), 16'd1);
    check("p6_ir", bus.ir_out, 16'h1000);
    reset = 1;
    req_log.delete();
    step();
    check("p6_rst_req", 16'(bus.imem_req), 16'd0);
    check("p6_rst_valid", 16'(bus.ir_valid), 16'd0);
    check("p6_rst_ir", bus.ir_out, 16'h0000);
    check("p6_rst_pc", bus.pc_out, 16'h0000);
    check("p6_rst_addr", bus.imem_addr, 16'h0000);
    reset = 0;
    delay_addr = 16'hFFFF;
    ready = 1;
    expect_ir(16'h1000, 16'h0000);
    wait_pops(base + 1);
    ready = 0;
    check("p6_log0", log_at(0), 16'h0000);
    check("sb_final", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
